// File: rtl/pipeline_rr_arbiter_pkg.sv
// pipeline_rr_arbiter_pkg: shared state enum, default constants and tag width helper
package pipe_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH, HOLD} state_t;
  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_MAX_BURST  = 4;
  localparam int DEF_FLUSH_HOLD = 3;
  function automatic int tag_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pipeline_rr_arbiter_if.sv
// pipeline_rr_arbiter_if: requester and pipeline-chain handshake bundle
//   master: requesters plus chain side (drives req_*, flush_req, pipe_stall)
//   slave : the arbiter (drives req_stall, pipe_*, busy)
interface pipeline_rr_arbiter_if import pipe_arb_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TAG_W   = tag_w(NUM_REQ)
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_stall;
  logic                      flush_req;
  logic                      pipe_stall;
  logic                      pipe_valid;
  logic [DATA_W-1:0]         pipe_data;
  logic [TAG_W-1:0]          pipe_tag;
  logic                      pipe_flush;
  logic                      busy;
  modport master (
    output req_valid, req_data, flush_req, pipe_stall,
    input  req_stall, pipe_valid, pipe_data, pipe_tag, pipe_flush, busy
  );
  modport slave (
    input  req_valid, req_data, flush_req, pipe_stall,
    output req_stall, pipe_valid, pipe_data, pipe_tag, pipe_flush, busy
  );
endinterface

// File: rtl/pipeline_rr_arbiter_picker.sv
// rr_priority_picker: first valid requester at or above i_ptr, wrapping at NUM_REQ
//   i_req_valid: request vector     i_ptr: highest-priority index
//   o_any: some request valid       o_grant: one-hot winner   o_idx: winner index
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req_valid,
  input  logic [TAG_W-1:0]   i_ptr,
  output logic               o_any,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [TAG_W-1:0]   o_idx
);
  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [TAG_W-1:0]     w_off;
  logic [TAG_W:0]       w_sum;
  // rotate so bit 0 is the pointer position, then take the lowest set bit
  assign w_dbl = {i_req_valid, i_req_valid};
  assign w_rot = NUM_REQ'(w_dbl >> i_ptr);
  always_comb begin
    w_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (w_rot[k]) w_off = TAG_W'(k);
  end
  assign w_sum   = {1'b0, i_ptr} + {1'b0, w_off};
  assign o_any   = |i_req_valid;
  assign o_idx   = (w_sum >= (TAG_W+1)'(NUM_REQ)) ? TAG_W'(w_sum - (TAG_W+1)'(NUM_REQ)) : TAG_W'(w_sum);
  assign o_grant = o_any ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << o_idx) : '0;
endmodule

// File: rtl/pipeline_rr_arbiter.sv
// pipeline_rr_arbiter: round-robin arbiter with burst limit feeding one pipeline slot, plus flush/hold sequencing
//   clk, reset (async, active-high)
//   bus (slave): req_valid/req_data/req_stall per requester, flush_req, pipe_stall in;
//                pipe_valid/pipe_data/pipe_tag/pipe_flush/busy out
module pipeline_rr_arbiter import pipe_arb_pkg::*; #(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MAX_BURST  = DEF_MAX_BURST,
  parameter int FLUSH_HOLD = DEF_FLUSH_HOLD
) (
  input logic clk,
  input logic reset,
  pipeline_rr_arbiter_if.slave bus
);
  localparam int TAG_W = tag_w(NUM_REQ);
  localparam int CW    = $clog2(MAX_BURST + 1);
  localparam int HW    = tag_w(FLUSH_HOLD);
  state_t              r_state;
  logic                r_valid;
  logic                r_flush;
  logic [DATA_W-1:0]   r_data;
  logic [TAG_W-1:0]    r_tag;
  logic [TAG_W-1:0]    r_ptr;
  logic [TAG_W-1:0]    r_last;
  logic [CW-1:0]       r_cnt;
  logic [HW-1:0]       r_hold;
  logic                w_any;
  logic [NUM_REQ-1:0]  w_grant;
  logic [TAG_W-1:0]    w_idx;
  logic                w_free;
  logic                w_load;
  logic [CW-1:0]       w_run;
  logic                w_rot;
  logic [TAG_W-1:0]    w_nxt;
  rr_priority_picker #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) u_pick (
    .i_req_valid(bus.req_valid),
    .i_ptr      (r_ptr),
    .o_any      (w_any),
    .o_grant    (w_grant),
    .o_idx      (w_idx)
  );
  assign w_free = !r_valid || !bus.pipe_stall;
  // reset is folded in so every requester sees stall while reset is asserted
  assign w_load = !reset && (r_state == IDLE || r_state == ACTIVE) && !bus.flush_req && w_free && w_any;
  assign w_run  = (w_idx == r_last) ? r_cnt + CW'(1) : CW'(1);
  assign w_rot  = w_run == CW'(MAX_BURST);
  assign w_nxt  = (w_idx == TAG_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
  assign bus.req_stall  = ~(w_load ? w_grant : '0);
  assign bus.pipe_valid = r_valid;
  assign bus.pipe_data  = r_data;
  assign bus.pipe_tag   = r_tag;
  assign bus.pipe_flush = r_flush;
  assign bus.busy       = r_valid || r_state == FLUSH || r_state == HOLD;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_flush <= 1'b0;
      r_data  <= '0;
      r_tag   <= '0;
      r_ptr   <= '0;
      r_last  <= '0;
      r_cnt   <= '0;
      r_hold  <= '0;
    end else if (bus.flush_req && r_state != FLUSH && r_state != HOLD) begin
      r_state <= FLUSH;
      r_flush <= 1'b1;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_tag   <= '0;
    end else if (r_state == FLUSH || r_state == HOLD) begin
      r_flush <= 1'b0;
      // a flush request during the hold restarts the quiet window
      if (bus.flush_req || r_state == FLUSH) begin
        r_state <= HOLD;
        r_hold  <= HW'(FLUSH_HOLD - 1);
      end else if (r_hold == '0) r_state <= IDLE;
      else r_hold <= r_hold - 1'b1;
    end else if (w_load) begin
      r_state <= ACTIVE;
      r_valid <= 1'b1;
      r_data  <= bus.req_data[w_idx*DATA_W +: DATA_W];
      r_tag   <= w_idx;
      r_last  <= w_idx;
      r_cnt   <= w_rot ? '0 : w_run;
      r_ptr   <= w_rot ? w_nxt : w_idx;
    end else if (r_valid && !bus.pipe_stall) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pipeline_rr_arbiter.sv
// tb_pipeline_rr_arbiter: random traffic on two arbiters (burst 1 and 4) checked against a behavioural model
module tb_pipeline_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int FH = 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  pipeline_rr_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus0 ();
  pipeline_rr_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus1 ();
  pipeline_rr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(1), .FLUSH_HOLD(FH)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0));
  pipeline_rr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(4), .FLUSH_HOLD(FH)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1));
  logic [N-1:0]    d_valid [2];
  logic [N*DW-1:0] d_data  [2];
  logic            d_stall;
  logic            d_flush;
  assign bus0.req_valid  = d_valid[0];
  assign bus0.req_data   = d_data[0];
  assign bus0.pipe_stall = d_stall;
  assign bus0.flush_req  = d_flush;
  assign bus1.req_valid  = d_valid[1];
  assign bus1.req_data   = d_data[1];
  assign bus1.pipe_stall = d_stall;
  assign bus1.flush_req  = d_flush;
  logic [N-1:0]  o_stall [2];
  logic          o_pv    [2];
  logic          o_pf    [2];
  logic          o_busy  [2];
  logic [DW-1:0] o_pd    [2];
  logic [1:0]    o_tag   [2];
  assign o_stall[0] = bus0.req_stall;
  assign o_pv[0]    = bus0.pipe_valid;
  assign o_pf[0]    = bus0.pipe_flush;
  assign o_busy[0]  = bus0.busy;
  assign o_pd[0]    = bus0.pipe_data;
  assign o_tag[0]   = bus0.pipe_tag;
  assign o_stall[1] = bus1.req_stall;
  assign o_pv[1]    = bus1.pipe_valid;
  assign o_pf[1]    = bus1.pipe_flush;
  assign o_busy[1]  = bus1.busy;
  assign o_pd[1]    = bus1.pipe_data;
  assign o_tag[1]   = bus1.pipe_tag;
  int checks = 0;
  int errors = 0;
  // model: mode 0 = normal (arbitrating), 1 = flush pulse cycle, 2 = quiet hold
  int          m_mode [2];
  int          m_hold [2];
  int          m_valid[2];
  logic [31:0] m_data [2];
  int          m_tag  [2];
  int          m_ptr  [2];
  int          m_run  [2];
  int          m_last [2];
  bit          rv  [2][N];
  int          seq [2][N];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [DW-1:0] beat(input int i, input int s);
    return {4'(i), 28'(s)};
  endfunction
  function automatic int mb(input int k);
    return (k == 0) ? 1 : 4;
  endfunction
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_hold[k] = 0; m_valid[k] = 0; m_data[k] = '0;
      m_tag[k] = 0; m_ptr[k] = 0; m_run[k] = 0; m_last[k] = 0;
    end
  endtask
  task automatic check_reset_outputs();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_stall%0d", k), 64'(o_stall[k]), 64'(4'b1111));
      check($sformatf("rst_valid%0d", k), 64'(o_pv[k]), 64'(0));
      check($sformatf("rst_busy%0d", k), 64'(o_busy[k]), 64'(0));
      check($sformatf("rst_flush%0d", k), 64'(o_pf[k]), 64'(0));
      check($sformatf("rst_data%0d", k), 64'(o_pd[k]), 64'(0));
      check($sformatf("rst_tag%0d", k), 64'(o_tag[k]), 64'(0));
    end
  endtask
  task automatic drive(input int pv, input int ps, input int pf);
    d_stall = int'($urandom_range(99)) < ps;
    d_flush = int'($urandom_range(99)) < pf;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) begin
        if (!rv[k][i]) rv[k][i] = int'($urandom_range(99)) < pv;
        d_valid[k][i] = rv[k][i];
        d_data[k][i*DW +: DW] = beat(i, seq[k][i]);
      end
  endtask
  task automatic eval(input int k);
    int w;
    logic [N-1:0] es;
    w = -1;
    if (m_mode[k] == 0 && !d_flush && (m_valid[k] == 0 || !d_stall))
      for (int j = 0; j < N; j++)
        if (w < 0 && rv[k][(m_ptr[k] + j) % N]) w = (m_ptr[k] + j) % N;
    es = '1;
    if (w >= 0) es[w] = 1'b0;
    check($sformatf("stall%0d", k), 64'(o_stall[k]), 64'(es));
    check($sformatf("valid%0d", k), 64'(o_pv[k]), 64'(m_valid[k]));
    check($sformatf("flush%0d", k), 64'(o_pf[k]), 64'(m_mode[k] == 1));
    check($sformatf("busy%0d", k), 64'(o_busy[k]), 64'(m_valid[k] != 0 || m_mode[k] != 0));
    if (m_valid[k] != 0 || m_mode[k] == 1) begin
      check($sformatf("data%0d", k), 64'(o_pd[k]), 64'(m_data[k]));
      check($sformatf("tag%0d", k), 64'(o_tag[k]), 64'(m_tag[k]));
    end
    if (m_mode[k] == 0 && d_flush) begin
      m_mode[k] = 1; m_valid[k] = 0; m_data[k] = '0; m_tag[k] = 0;
    end else if (m_mode[k] == 1) begin
      m_mode[k] = 2; m_hold[k] = FH;
    end else if (m_mode[k] == 2) begin
      if (d_flush) m_hold[k] = FH;
      else begin
        m_hold[k]--;
        if (m_hold[k] == 0) m_mode[k] = 0;
      end
    end else if (w >= 0) begin
      m_valid[k] = 1;
      m_data[k]  = beat(w, seq[k][w]);
      m_tag[k]   = w;
      seq[k][w]++;
      rv[k][w]   = 1'b0;
      m_run[k]   = (w == m_last[k]) ? m_run[k] + 1 : 1;
      m_last[k]  = w;
      if (m_run[k] == mb(k)) begin
        m_ptr[k] = (w + 1) % N;
        m_run[k] = 0;
      end else m_ptr[k] = w;
    end else if (m_valid[k] != 0 && !d_stall) m_valid[k] = 0;
  endtask
  task automatic run(input int n, input int pv, input int ps, input int pf);
    repeat (n) begin
      drive(pv, ps, pf);
      #1;
      eval(0);
      eval(1);
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    d_stall = 1'b0;
    d_flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      d_valid[k] = '0;
      d_data[k]  = '0;
      for (int i = 0; i < N; i++) begin
        rv[k][i]  = 1'b0;
        seq[k][i] = 0;
      end
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    reset = 1'b0;
    run(40, 100, 0, 0);
    run(150, 60, 30, 5);
    run(120, 50, 20, 25);
    drive(80, 30, 0);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs();
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    run(40, 100, 0, 0);
    run(120, 70, 40, 8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
